// File: rtl/scan_pkg.sv
// Purpose: shared constants for the LED scan sequencer (FSM encoding, index and speed widths).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package scan_pkg;

  // FSM state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  localparam int         IDX_W   = 4;
  localparam logic [3:0] IDX_MAX = 4'd15;
  localparam int         SPEED_W = 2;

endpackage : scan_pkg

// File: rtl/scan_prescaler.sv
// Purpose: programmable timebase; raises tick on the cycle its count reaches div-1.
// Latency: tick is combinational from the count register; count updates on the next edge.
// Backpressure: en=0 freezes the count; clr forces it to zero and overrides en.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear of the count
//   en         : advance the count this cycle (tick is suppressed when low)
//   div        : requested divisor; 0 is treated as 1
//   tick       : high when the current cycle ends a divisor period
module scan_prescaler #(
  parameter int CNT_W = 21
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [CNT_W:0] div,
  output logic         tick
);

  localparam logic [CNT_W:0] ONE = (CNT_W+1)'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   div_c;
  logic [CNT_W:0]   div_m1;

  // A shift of PRESCALE can reach zero; a zero divisor would never tick.
  assign div_c  = (div == '0) ? ONE : div;
  assign div_m1 = div_c - ONE;

  // ">=" rather than "==" so a divisor that shrinks mid-count ticks
  // immediately instead of letting the counter run past it.
  assign tick = en && ({1'b0, cnt_q} >= div_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) cnt_d = '0;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule : scan_prescaler

// File: rtl/led_scan_sequencer.sv
// Purpose: generates the wrapping 0..15 scan index for the LED bounce decoder, with run/pause,
//          speed select and one-shot (single 16-step sweep) modes.
// Latency: all outputs registered; first index step lands div edges after the edge taking start.
// Backpressure: run=0 freezes index and prescaler; start restarts from index 0 in any state.
//
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : 1-cycle pulse, (re)start from index 0
//   run        : level, 1 advances, 0 pauses
//   oneshot    : level, sampled at each tick; stop after the 15->0 wrap
//   speed      : divisor = max(PRESCALE >> speed, 1)
//   idx        : scan index to the decoder
//   step       : 1-cycle pulse in the cycle idx shows its new value
//   busy       : high while running or paused
//   done       : 1-cycle pulse when a one-shot sweep completes
module led_scan_sequencer
  import scan_pkg::*;
#(
  parameter int PRESCALE = 1500000,
  parameter int CNT_W    = 21
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic               oneshot,
  input  logic [SPEED_W-1:0] speed,
  output logic [IDX_W-1:0]   idx,
  output logic               step,
  output logic               busy,
  output logic               done
);

  localparam logic [CNT_W:0] PRESCALE_V = (CNT_W+1)'(PRESCALE);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W:0]   div_raw;
  logic             presc_en;
  logic             tick;

  assign div_raw  = PRESCALE_V >> speed;
  // The prescaler only advances on edges where the FSM stays in RUN; a
  // coincident run=0 pauses instead of ticking, and start clears it.
  assign presc_en = (state_q == S_RUN) && run;

  scan_prescaler #(
    .CNT_W (CNT_W)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (presc_en),
    .div   (div_raw),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (start) state_d = run ? S_RUN : S_PAUSE;
      end

      S_RUN: begin
        // start outranks both pause and a coincident tick.
        if (start) begin
          idx_d   = '0;
          state_d = run ? S_RUN : S_PAUSE;
        end else if (!run) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          idx_d  = idx_q + 1'b1;
          step_d = 1'b1;
          if ((idx_q == IDX_MAX) && oneshot) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_PAUSE: begin
        if (start) begin
          idx_d   = '0;
          state_d = run ? S_RUN : S_PAUSE;
        end else if (run) begin
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign idx  = idx_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : led_scan_sequencer
